// File: rtl/mem_reader_pkg.sv
// Shared types and constants for the memory reader: FSM state encoding,
// bus widths and the active-low seven-segment glyph table.
package mem_reader_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Segment order gfedcba, a 0 lights the segment.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/mem_reader_seg7_dec.sv
// Hex digit to active-low seven-segment decoder; purely combinational.
module seg7_dec
  import mem_reader_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/mem_reader.sv
// 16x8 register memory with a display reader: steps through addresses
// automatically in RUN or one at a time from a button while IDLE.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int DEPTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key0,
  input  logic              key1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic              busy
);

  localparam int CNT_W = 26;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic              key0_meta_r;
  logic              key0_sync_r;
  logic              key0_prev_r;
  logic              key1_meta_r;
  logic              key1_sync_r;
  logic              key1_prev_r;
  logic [1:0]        arm_cnt_r;
  logic              armed_s;
  logic              push0_s;
  logic              push1_s;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [CNT_W-1:0]  cnt_r;
  state_t            state_r;
  logic              busy_r;

  // Edges are suppressed until the synchronizer has settled after reset, so a
  // key already held when reset releases never looks like a fresh press.
  assign armed_s = (arm_cnt_r == 2'd3);
  assign push0_s = key0_sync_r & ~key0_prev_r & armed_s;
  assign push1_s = key1_sync_r & ~key1_prev_r & armed_s;

  // Two-flop synchronizers, previous-level flops and the post-reset arm counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key0_meta_r <= 1'b0;
      key0_sync_r <= 1'b0;
      key0_prev_r <= 1'b0;
      key1_meta_r <= 1'b0;
      key1_sync_r <= 1'b0;
      key1_prev_r <= 1'b0;
      arm_cnt_r   <= 2'd0;
    end else begin
      key0_meta_r <= key0;
      key0_sync_r <= key0_meta_r;
      key0_prev_r <= key0_sync_r;
      key1_meta_r <= key1;
      key1_sync_r <= key1_meta_r;
      key1_prev_r <= key1_sync_r;
      if (!armed_s) begin
        arm_cnt_r <= arm_cnt_r + 2'd1;
      end
    end
  end

  // Memory array writes and the read-first registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      rd_data_r <= 8'h00;
    end else begin
      if (wr_en) begin
        mem_r[wr_addr] <= wr_data;
      end
      rd_data_r <= mem_r[rd_addr_r];
    end
  end

  // Reader FSM: owns state, read address, hold counter and the busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rd_addr_r <= 4'd0;
      cnt_r     <= 26'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (push0_s) begin
            state_r <= RUN;
            cnt_r   <= 26'd0;
            busy_r  <= 1'b1;
          end else if (push1_s) begin
            rd_addr_r <= rd_addr_r + 4'd1;
          end
        end
        RUN: begin
          if (cnt_r == HOLD_LAST) begin
            cnt_r     <= 26'd0;
            rd_addr_r <= rd_addr_r + 4'd1;
          end else begin
            cnt_r <= cnt_r + 26'd1;
          end
          // Stop wins over the counter update but not over a due address step.
          if (push0_s) begin
            state_r <= IDLE;
            cnt_r   <= 26'd0;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 26'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;

  seg7_dec u_hex0 (.digit(rd_data_r[3:0]), .seg(HEX0));
  seg7_dec u_hex1 (.digit(rd_data_r[7:4]), .seg(HEX1));
  seg7_dec u_hex2 (.digit(rd_addr_r),      .seg(HEX2));

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader with HOLD_CYCLES=4: expectations are queued as
// stimulus is applied and popped when the display is sampled.
module tb_mem_reader;

  logic       clk;
  logic       rst_n;
  logic       key0;
  logic       key1;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic       busy;

  typedef struct {
    string      tag;
    logic [3:0] addr;
    logic [7:0] data;
    logic       busy;
    bit         chk_data;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  mem_reader #(.HOLD_CYCLES(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .key0(key0), .key1(key1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b1000110;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic [3:0] addr,
                              input logic [7:0] data, input logic b, input bit cd);
    exp_t e;
    e.tag = tag; e.addr = addr; e.data = data; e.busy = b; e.chk_data = cd;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      assert (HEX2 === seg_of(e.addr)) else begin
        mismatched++;
        $error("FAIL %s.HEX2 observed=%b expected=%b", e.tag, HEX2, seg_of(e.addr));
      end
      compared++;
      assert (busy === e.busy) else begin
        mismatched++;
        $error("FAIL %s.busy observed=%b expected=%b", e.tag, busy, e.busy);
      end
      if (e.chk_data) begin
        compared++;
        assert (HEX1 === seg_of(e.data[7:4])) else begin
          mismatched++;
          $error("FAIL %s.HEX1 observed=%b expected=%b", e.tag, HEX1, seg_of(e.data[7:4]));
        end
        compared++;
        assert (HEX0 === seg_of(e.data[3:0])) else begin
          mismatched++;
          $error("FAIL %s.HEX0 observed=%b expected=%b", e.tag, HEX0, seg_of(e.data[3:0]));
        end
      end
    end
  endtask

  // Raise the selected keys for two cycles; returns on the second negedge.
  task automatic pulse(input logic k0, input logic k1);
    key0 = k0;
    key1 = k1;
    tick(2);
    key0 = 1'b0;
    key1 = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; key0 = 1'b0; key1 = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'h00;
    #1;
    expect_state("reset", 4'd0, 8'h00, 1'b0, 1'b1);
    check_out();

    tick(2);
    rst_n = 1'b1;
    tick(4);

    // Load two words while IDLE at address 0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h3C;
    tick(1);
    wr_addr = 4'd1; wr_data = 8'hA5;
    tick(1);
    wr_en = 1'b0;
    expect_state("idle_addr0", 4'd0, 8'h3C, 1'b0, 1'b1);
    tick(2);
    check_out();

    pulse(1'b0, 1'b1);
    expect_state("step_addr1", 4'd1, 8'hA5, 1'b0, 1'b1);
    tick(2);
    check_out();

    // Start running; first address step comes 4 cycles after entering RUN.
    pulse(1'b1, 1'b0);
    expect_state("run_start", 4'd1, 8'hA5, 1'b1, 1'b1);
    tick(1);
    check_out();

    expect_state("run_addr2", 4'd2, 8'h00, 1'b1, 1'b0);
    tick(4);
    check_out();
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h7E;
    expect_state("rf_old", 4'd2, 8'h00, 1'b1, 1'b1);
    tick(1);
    wr_en = 1'b0;
    check_out();
    expect_state("rf_new", 4'd2, 8'h7E, 1'b1, 1'b1);
    tick(1);
    check_out();

    tick(2);
    for (int k = 2; k <= 16; k++) begin
      expect_state($sformatf("run_step%0d", k), 4'((1 + k) % 16), 8'h00, 1'b1, 1'b0);
      check_out();
      if (k != 16) tick(4);
    end

    pulse(1'b1, 1'b0);
    expect_state("stop", 4'd1, 8'hA5, 1'b0, 1'b1);
    tick(1);
    check_out();
    expect_state("frozen", 4'd1, 8'hA5, 1'b0, 1'b1);
    tick(8);
    check_out();

    // Both keys together: start only, no extra IDLE step.
    pulse(1'b1, 1'b1);
    expect_state("both_keys", 4'd1, 8'hA5, 1'b1, 1'b0);
    tick(1);
    check_out();

    // key1 while running must not add a step.
    pulse(1'b0, 1'b1);
    expect_state("run_addr5", 4'd5, 8'h00, 1'b1, 1'b0);
    tick(14);
    check_out();

    #2;
    rst_n = 1'b0;
    expect_state("async_reset", 4'd0, 8'h00, 1'b0, 1'b1);
    #1;
    check_out();

    // Writes during reset are dropped; key0 held through release is not a push.
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; key0 = 1'b1;
    tick(2);
    wr_en = 1'b0;
    rst_n = 1'b1;
    expect_state("held_key", 4'd0, 8'h00, 1'b0, 1'b1);
    tick(6);
    check_out();
    key0 = 1'b0;
    tick(4);

    pulse(1'b0, 1'b1);
    expect_state("mem_cleared", 4'd1, 8'h00, 1'b0, 1'b1);
    tick(2);
    check_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
